// File: rtl/kf_update_semipar_pkg.sv
// Shared fixed-point constants and FSM state encoding for the 2-state Kalman
// measurement-update block.
package kf_update_semipar_pkg;

  localparam int FXP_N    = 16;
  localparam int FXP_FRAC = 8;
  localparam int FXP_ONE  = 1 << FXP_FRAC;
  localparam int FXP_MAX  = (1 << (FXP_N - 1)) - 1;
  localparam int FXP_MIN  = -(1 << (FXP_N - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_INNOV,
    S_XUPD,
    S_KH,
    S_PUPD,
    S_DONE
  } state_t;

  // Vector phases (innovation, state update) walk two elements; matrix phases walk four.
  function automatic logic [1:0] last_idx(input state_t s);
    return (s == S_INNOV || s == S_XUPD) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/kf_update_semipar_dot2.sv
// Combinational a*b + c*d in signed fixed point, rounded half-up at the
// FRAC position and saturated back to N bits.
module fxp_dot2 #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  output logic signed [N-1:0] y
);

  localparam int W = 2 * N + 1;
  localparam logic signed [W-1:0] RND = W'(1) << (FRAC - 1);
  localparam logic signed [W-1:0] HI  = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [W-1:0] LO  = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

  logic signed [2*N-1:0] p0, p1;
  logic signed [W-1:0]   sum, shifted;

  // The extra sum bit absorbs the worst case (-2^(N-1))^2 twice plus rounding.
  always_comb begin
    p0      = (2*N)'(a) * (2*N)'(b);
    p1      = (2*N)'(c) * (2*N)'(d);
    sum     = W'(p0) + W'(p1) + RND;
    shifted = sum >>> FRAC;
    if (shifted > HI)
      y = {1'b0, {(N - 1){1'b1}}};
    else if (shifted < LO)
      y = {1'b1, {(N - 1){1'b0}}};
    else
      y = shifted[N-1:0];
  end

endmodule

// File: rtl/kf_update_semipar.sv
// 2-state Kalman measurement update (x_post, P_post) computed one dot product
// per cycle through a single shared fxp_dot2.
module kf_update_semipar
  import kf_update_semipar_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_prior0,
  input  logic [N-1:0] x_prior1,
  input  logic [N-1:0] z0,
  input  logic [N-1:0] z1,
  input  logic [N-1:0] h00,
  input  logic [N-1:0] h01,
  input  logic [N-1:0] h10,
  input  logic [N-1:0] h11,
  input  logic [N-1:0] K00,
  input  logic [N-1:0] K01,
  input  logic [N-1:0] K10,
  input  logic [N-1:0] K11,
  input  logic [N-1:0] p_prior00,
  input  logic [N-1:0] p_prior01,
  input  logic [N-1:0] p_prior10,
  input  logic [N-1:0] p_prior11,
  output logic         done,
  output logic [N-1:0] x_post0,
  output logic [N-1:0] x_post1,
  output logic [N-1:0] p_post00,
  output logic [N-1:0] p_post01,
  output logic [N-1:0] p_post10,
  output logic [N-1:0] p_post11
);

  localparam logic signed [N-1:0] ONE = N'(1) << FRAC;

  state_t state, state_n;
  logic [1:0] idx;
  logic last, busy, done_d;

  logic signed [N-1:0] xr [2];
  logic signed [N-1:0] zr [2];
  logic signed [N-1:0] hr [4];
  logic signed [N-1:0] kr [4];
  logic signed [N-1:0] pr [4];
  logic signed [N-1:0] yr [2];
  logic signed [N-1:0] ar [4];
  logic signed [N-1:0] xq [2];
  logic signed [N-1:0] pq [4];

  logic signed [N-1:0] da, db, dc, dd, dot, base, acc;
  logic                sub;
  logic signed [N:0]   ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_INNOV;
      S_INNOV: if (last) state_n = S_XUPD;
      S_XUPD:  if (last) state_n = S_KH;
      S_KH:    if (last) state_n = S_PUPD;
      S_PUPD:  if (last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_INNOV) || (state == S_XUPD) ||
             (state == S_KH)    || (state == S_PUPD);
    last   = (idx == last_idx(state));
    done_d = (state == S_DONE);
  end

  // Operand steering: idx[1] selects row i, idx[0] selects column j (or element in vector phases).
  always_comb begin
    da   = '0;
    db   = '0;
    dc   = '0;
    dd   = '0;
    base = '0;
    sub  = 1'b0;
    unique case (state)
      S_INNOV: begin
        da   = hr[{idx[0], 1'b0}];
        db   = xr[0];
        dc   = hr[{idx[0], 1'b1}];
        dd   = xr[1];
        base = zr[idx[0]];
        sub  = 1'b1;
      end
      S_XUPD: begin
        da   = kr[{idx[0], 1'b0}];
        db   = yr[0];
        dc   = kr[{idx[0], 1'b1}];
        dd   = yr[1];
        base = xr[idx[0]];
      end
      S_KH: begin
        da   = kr[{idx[1], 1'b0}];
        db   = hr[{1'b0, idx[0]}];
        dc   = kr[{idx[1], 1'b1}];
        dd   = hr[{1'b1, idx[0]}];
        base = (idx[1] == idx[0]) ? ONE : '0;
        sub  = 1'b1;
      end
      S_PUPD: begin
        da = ar[{idx[1], 1'b0}];
        db = pr[{1'b0, idx[0]}];
        dc = ar[{idx[1], 1'b1}];
        dd = pr[{1'b1, idx[0]}];
      end
      default: ;
    endcase
  end

  fxp_dot2 #(.N(N), .FRAC(FRAC)) u_dot (
    .a(da),
    .b(db),
    .c(dc),
    .d(dd),
    .y(dot)
  );

  // Overflow at N+1 bits shows up as the top two bits disagreeing.
  always_comb begin
    ext = sub ? ((N+1)'(base) - (N+1)'(dot)) : ((N+1)'(base) + (N+1)'(dot));
    if (ext[N] != ext[N-1])
      acc = ext[N] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
    else
      acc = ext[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      idx  <= 2'd0;
      xr   <= '{default: '0};
      zr   <= '{default: '0};
      hr   <= '{default: '0};
      kr   <= '{default: '0};
      pr   <= '{default: '0};
      yr   <= '{default: '0};
      ar   <= '{default: '0};
      xq   <= '{default: '0};
      pq   <= '{default: '0};
    end else begin
      done <= done_d;
      if (state == S_IDLE && start) begin
        xr  <= '{x_prior0, x_prior1};
        zr  <= '{z0, z1};
        hr  <= '{h00, h01, h10, h11};
        kr  <= '{K00, K01, K10, K11};
        pr  <= '{p_prior00, p_prior01, p_prior10, p_prior11};
        idx <= 2'd0;
      end else if (busy) begin
        idx <= last ? 2'd0 : idx + 2'd1;
      end
      unique case (state)
        S_INNOV: yr[idx[0]] <= acc;
        S_XUPD:  xq[idx[0]] <= acc;
        S_KH:    ar[idx]    <= acc;
        S_PUPD:  pq[idx]    <= dot;
        default: ;
      endcase
    end
  end

  assign x_post0  = xq[0];
  assign x_post1  = xq[1];
  assign p_post00 = pq[0];
  assign p_post01 = pq[1];
  assign p_post10 = pq[2];
  assign p_post11 = pq[3];

endmodule

// File: tb/tb_kf_update_semipar.sv
// Scoreboard bench for kf_update_semipar: each scenario pushes the expected
// posterior when it issues start and pops/compares it when done arrives.
module tb_kf_update_semipar;
  import kf_update_semipar_pkg::*;

  localparam int N = FXP_N;
  localparam int W6 = 6 * N;

  typedef logic signed [N-1:0] word_t;
  typedef struct {
    logic [W6-1:0] v;
    int            tol;
  } exp_t;

  logic clk, rst_n, start, done;
  logic [N-1:0] x_prior0, x_prior1, z0, z1;
  logic [N-1:0] h00, h01, h10, h11, K00, K01, K10, K11;
  logic [N-1:0] p_prior00, p_prior01, p_prior10, p_prior11;
  logic [N-1:0] x_post0, x_post1, p_post00, p_post01, p_post10, p_post11;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  localparam word_t WMAX = word_t'(FXP_MAX);
  localparam word_t WMIN = word_t'(FXP_MIN);
  localparam word_t W1   = word_t'(FXP_ONE);
  localparam word_t W0   = '0;

  kf_update_semipar dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_prior0(x_prior0), .x_prior1(x_prior1), .z0(z0), .z1(z1),
    .h00(h00), .h01(h01), .h10(h10), .h11(h11),
    .K00(K00), .K01(K01), .K10(K10), .K11(K11),
    .p_prior00(p_prior00), .p_prior01(p_prior01),
    .p_prior10(p_prior10), .p_prior11(p_prior11),
    .done(done),
    .x_post0(x_post0), .x_post1(x_post1),
    .p_post00(p_post00), .p_post01(p_post01),
    .p_post10(p_post10), .p_post11(p_post11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t fx(input real r);
    return word_t'($rtoi(r * FXP_ONE + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Order: x_post0, x_post1, p_post00, p_post01, p_post10, p_post11 (MSB first).
  function automatic logic [W6-1:0] outs();
    return {x_post0, x_post1, p_post00, p_post01, p_post10, p_post11};
  endfunction

  task automatic setInputs(input word_t xa, xb, za, zb,
                           input logic [4*N-1:0] hm, km, pm);
    x_prior0 = xa;  x_prior1 = xb;  z0 = za;  z1 = zb;
    {h00, h01, h10, h11} = hm;
    {K00, K01, K10, K11} = km;
    {p_prior00, p_prior01, p_prior10, p_prior11} = pm;
  endtask

  task automatic applyStimulus(input logic [W6-1:0] ev, input int tol);
    exp_t e;
    e.v   = ev;
    e.tol = tol;
    sb.push_back(e);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    setInputs(W0, W0, W0, W0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b required 0", done);
    end
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0", outs());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_diagonal();
    int n;
    exp_t e;
    logic [W6-1:0] got;
    int d;
    setInputs(W0, W0, W1, fx(-0.5), {W1, W0, W0, W1}, {fx(0.8), W0, W0, fx(0.8)},
              {W1, W0, W0, W1});
    applyStimulus({fx(0.8), fx(-0.4), fx(0.2), W0, W0, fx(0.2)}, 2);
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (n != 14) begin
      errors++;
      $display("[TB] FAIL diag_latency: done seen at negedge %0d, required 14", n);
    end
    e   = sb.pop_front();
    got = outs();
    for (int k = 0; k < 6; k++) begin
      checks++;
      d = int'($signed(got[(5-k)*N +: N])) - int'($signed(e.v[(5-k)*N +: N]));
      if ($isunknown(got[(5-k)*N +: N]) || d > e.tol || d < -e.tol) begin
        errors++;
        $display("[TB] FAIL diag_out%0d: got %0d required %0d +/- %0d", k,
                 $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]), e.tol);
      end
    end
  endtask

  task automatic test_zero_gain();
    int n;
    exp_t e;
    logic [W6-1:0] got;
    setInputs(fx(1.0), fx(2.0), fx(5.0), fx(5.0), {W1, W0, W0, W1}, '0,
              {fx(2.0), fx(0.5), fx(0.5), fx(1.0)});
    applyStimulus({fx(1.0), fx(2.0), fx(2.0), fx(0.5), fx(0.5), fx(1.0)}, 0);
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_gain_done: got %b required 1 within 30 cycles", done);
    end
    e   = sb.pop_front();
    got = outs();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[(5-k)*N +: N] !== e.v[(5-k)*N +: N]) begin
        errors++;
        $display("[TB] FAIL zero_gain_out%0d: got %0d required %0d", k,
                 $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]));
      end
    end
  endtask

  task automatic test_full();
    int n;
    exp_t e;
    logic [W6-1:0] got;
    int d;
    setInputs(fx(1.0), fx(2.0), fx(2.0), fx(1.0), {W1, W0, W0, W1},
              {fx(0.5), fx(0.25), W0, fx(0.5)}, {fx(2.0), fx(0.5), fx(0.5), fx(1.0)});
    applyStimulus({fx(1.25), fx(1.5), fx(0.875), W0, fx(0.25), fx(0.5)}, 2);
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_done: got %b required 1 within 30 cycles", done);
    end
    e   = sb.pop_front();
    got = outs();
    for (int k = 0; k < 6; k++) begin
      checks++;
      d = int'($signed(got[(5-k)*N +: N])) - int'($signed(e.v[(5-k)*N +: N]));
      if ($isunknown(got[(5-k)*N +: N]) || d > e.tol || d < -e.tol) begin
        errors++;
        $display("[TB] FAIL full_out%0d: got %0d required %0d +/- %0d", k,
                 $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]), e.tol);
      end
    end
  endtask

  // Run A: y clamps to MIN/MAX, so x_post = x + clamp(y) = -1 for both
  // elements; a wrapped y would instead drive x_post to a rail. Run B pushes
  // the final add itself past both rails.
  task automatic test_saturation();
    int n;
    exp_t e;
    logic [W6-1:0] got;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        setInputs(WMAX, WMIN, WMIN, WMAX, {W1, W0, W0, W1}, {W1, W0, W0, W1},
                  {W1, W0, W0, W1});
        applyStimulus({word_t'(-1), word_t'(-1), W0, W0, W0, W0}, 0);
      end else begin
        setInputs(WMAX, WMIN, WMAX, WMIN, '0, {W1, W0, W0, W1}, {W1, W0, W0, W1});
        applyStimulus({WMAX, WMIN, W1, W0, W0, W1}, 0);
      end
      n = 0;
      while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sat%0d_done: got %b required 1 within 30 cycles", r, done);
      end
      e   = sb.pop_front();
      got = outs();
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[(5-k)*N +: N] !== e.v[(5-k)*N +: N]) begin
          errors++;
          $display("[TB] FAIL sat%0d_out%0d: got %0d required %0d", r, k,
                   $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, dcount, done_at;
    exp_t e, e2;
    logic [W6-1:0] got;
    setInputs(fx(1.0), fx(2.0), fx(2.0), fx(1.0), {W1, W0, W0, W1},
              {fx(0.5), fx(0.25), W0, fx(0.5)}, {fx(2.0), fx(0.5), fx(0.5), fx(1.0)});
    applyStimulus({fx(1.25), fx(1.5), fx(0.875), W0, fx(0.25), fx(0.5)}, 0);
    dcount  = 0;
    done_at = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin dcount++; done_at = k; end
      start = (k == 2 || k == 12 || k == 13);
      if (k == 2)
        setInputs(fx(1.0), fx(2.0), fx(5.0), fx(5.0), {W1, W0, W0, W1}, '0,
                  {fx(2.0), fx(0.5), fx(0.5), fx(1.0)});
      if (k == 13) begin
        e2.v   = {fx(1.0), fx(2.0), fx(2.0), fx(0.5), fx(0.5), fx(1.0)};
        e2.tol = 0;
        sb.push_back(e2);
      end
    end
    start = 1'b0;
    checks++;
    if (dcount != 1 || done_at != 13) begin
      errors++;
      $display("[TB] FAIL b2b_done_timing: %0d pulses, last after edge %0d; required 1 after edge 13",
               dcount, done_at);
    end
    e   = sb.pop_front();
    got = outs();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[(5-k)*N +: N] !== e.v[(5-k)*N +: N]) begin
        errors++;
        $display("[TB] FAIL b2b_first_out%0d: got %0d required %0d", k,
                 $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]));
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (n != 14) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency: done seen at negedge %0d, required 14", n);
    end
    e   = sb.pop_front();
    got = outs();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[(5-k)*N +: N] !== e.v[(5-k)*N +: N]) begin
        errors++;
        $display("[TB] FAIL b2b_second_out%0d: got %0d required %0d", k,
                 $signed(got[(5-k)*N +: N]), $signed(e.v[(5-k)*N +: N]));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int dcount;
    exp_t e;
    setInputs(W0, W0, W1, fx(-0.5), {W1, W0, W0, W1}, {fx(0.8), W0, W0, fx(0.8)},
              {W1, W0, W0, W1});
    applyStimulus({fx(0.8), fx(-0.4), fx(0.2), W0, W0, fx(0.2)}, 2);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || outs() !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_clear: done=%b outputs=%h required 0/0", done, outs());
    end
    e = sb.pop_back();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0 || outs() !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: %0d pulses, outputs=%h required 0 pulses, 0",
               dcount, outs());
    end
    test_diagonal();
  endtask

  initial begin
    test_reset();
    test_diagonal();
    test_zero_gain();
    test_full();
    test_saturation();
    test_back_to_back();
    test_reset_midrun();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
